// File: rtl/tinyqv_fetch_pkg.sv
// Shared definitions for the TinyQV instruction prefetch unit.
// Sequencer state encoding and decoder take codes.
package tinyqv_fetch_pkg;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        STREAM     = 2'd1,
        FLUSH      = 2'd2
    } fetch_state_t;

    localparam logic [1:0] TAKE_NONE = 2'b00;
    localparam logic [1:0] TAKE_HW   = 2'b01;
    localparam logic [1:0] TAKE_WORD = 2'b10;

endpackage

// File: rtl/tinyqv_hw_fifo.sv
// 4-entry halfword FIFO with a two-entry read window.
// Ports: clk, rstn, clear, push/push_data, pop1/pop2, count, rd_data.
module tinyqv_hw_fifo (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop1,
    input  logic        pop2,
    output logic [2:0]  count,
    output logic [31:0] rd_data
);

    logic [15:0] mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr_nx;
    logic [2:0]  pop_n;

    assign pop_n     = pop2 ? 3'd2 : (pop1 ? 3'd1 : 3'd0);
    assign rd_ptr_nx = rd_ptr + 2'd1;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            rd_ptr <= rd_ptr + pop_n[1:0];
            count  <= count + 3'(push) - pop_n;
        end
    end

    // Storage needs no reset: entries beyond count are masked.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    assign rd_data[15:0]  = (count >= 3'd1) ? mem[rd_ptr]    : 16'h0;
    assign rd_data[31:16] = (count >= 3'd2) ? mem[rd_ptr_nx] : 16'h0;

endmodule

// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetch sequencer: byte assembly, fetch FSM, PC tracking.
// Ports: jump/jump_addr, instr_* to decoder, fetch_* to memory controller.
module tinyqv_instr_prefetch
    import tinyqv_fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [22:0] RESET_ADDR = 23'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump,
    input  logic [22:0] jump_addr,
    input  logic [1:0]  instr_take,
    output logic [31:0] instr_data,
    output logic [2:0]  instr_count,
    output logic [22:0] instr_pc,
    output logic [22:0] fetch_addr,
    output logic        fetch_restart,
    output logic        fetch_stall,
    input  logic        fetch_started,
    input  logic        fetch_stopped,
    input  logic [7:0]  fetch_byte,
    input  logic        fetch_byte_valid
);

    localparam logic [2:0] FULL      = 3'(DEPTH);
    localparam logic [3:0] STALL_LVL = 4'(2 * DEPTH - 1);

    fetch_state_t state_q, state_d;
    logic         partial_q, partial_d;
    logic [7:0]   low_q, low_d;
    logic [22:0]  tail_q, tail_d;
    logic [22:0]  pc_q, pc_d;
    logic         restart_q, stall_q;
    logic         restart_d, stall_d;

    logic [2:0]   count, count_d;
    logic [3:0]   level_d;
    logic         take1, take2;
    logic         push, pop1, pop2, clear;

    assign take1 = (instr_take == TAKE_HW) && (count != 3'd0);
    assign take2 = (instr_take == TAKE_WORD) && (count >= 3'd2);

    always_comb begin
        state_d   = state_q;
        partial_d = partial_q;
        low_d     = low_q;
        tail_d    = tail_q;
        pc_d      = pc_q;
        push      = 1'b0;
        pop1      = 1'b0;
        pop2      = 1'b0;
        clear     = 1'b0;
        if (jump) begin
            clear     = 1'b1;
            partial_d = 1'b0;
            tail_d    = jump_addr;
            pc_d      = jump_addr;
            state_d   = FLUSH;
        end else begin
            pop1 = take1;
            pop2 = take2;
            pc_d = pc_q + 23'({take2, take1});
            case (state_q)
                WAIT_START: begin
                    if (fetch_started)
                        state_d = STREAM;
                end
                STREAM: begin
                    if (fetch_byte_valid) begin
                        if (!partial_q) begin
                            low_d     = fetch_byte;
                            partial_d = 1'b1;
                        end else if (count != FULL || take1 || take2) begin
                            push      = 1'b1;
                            tail_d    = tail_q + 23'd1;
                            partial_d = 1'b0;
                        end
                    end
                    // A half-received halfword is dropped and refetched.
                    if (fetch_stopped) begin
                        partial_d = 1'b0;
                        state_d   = WAIT_START;
                    end
                end
                FLUSH: begin
                    if (fetch_stopped)
                        state_d = WAIT_START;
                end
                default: state_d = WAIT_START;
            endcase
        end
        count_d = jump ? 3'd0 :
                  count + 3'(push) - (take2 ? 3'd2 : 3'(take1));
        // Stall leaves room for one more byte in the cycle it rises.
        level_d   = {count_d, 1'b0} + 4'(partial_d);
        restart_d = (state_d != STREAM);
        stall_d   = (state_d == FLUSH) ||
                    ((state_d == STREAM) && (level_d >= STALL_LVL));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= WAIT_START;
            partial_q <= 1'b0;
            low_q     <= 8'h0;
            tail_q    <= RESET_ADDR;
            pc_q      <= RESET_ADDR;
            restart_q <= 1'b1;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            partial_q <= partial_d;
            low_q     <= low_d;
            tail_q    <= tail_d;
            pc_q      <= pc_d;
            restart_q <= restart_d;
            stall_q   <= stall_d;
        end
    end

    tinyqv_hw_fifo u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .push      (push),
        .push_data ({fetch_byte, low_q}),
        .pop1      (pop1),
        .pop2      (pop2),
        .count     (count),
        .rd_data   (instr_data)
    );

    assign instr_count   = count;
    assign instr_pc      = pc_q;
    assign fetch_addr    = tail_q;
    assign fetch_restart = restart_q;
    assign fetch_stall   = stall_q;

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
// Self-checking bench for tinyqv_instr_prefetch.
// Directed scenarios plus randomized traffic against a queue model.
module tb_tinyqv_instr_prefetch;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jump = 1'b0;
    logic [22:0] jump_addr = '0;
    logic [1:0]  instr_take = '0;
    logic [31:0] instr_data;
    logic [2:0]  instr_count;
    logic [22:0] instr_pc;
    logic [22:0] fetch_addr;
    logic        fetch_restart;
    logic        fetch_stall;
    logic        fetch_started = 1'b0;
    logic        fetch_stopped = 1'b0;
    logic [7:0]  fetch_byte = '0;
    logic        fetch_byte_valid = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tinyqv_instr_prefetch dut (
        .clk              (clk),
        .rstn             (rstn),
        .jump             (jump),
        .jump_addr        (jump_addr),
        .instr_take       (instr_take),
        .instr_data       (instr_data),
        .instr_count      (instr_count),
        .instr_pc         (instr_pc),
        .fetch_addr       (fetch_addr),
        .fetch_restart    (fetch_restart),
        .fetch_stall      (fetch_stall),
        .fetch_started    (fetch_started),
        .fetch_stopped    (fetch_stopped),
        .fetch_byte       (fetch_byte),
        .fetch_byte_valid (fetch_byte_valid)
    );

    // Reference model: halfword queue, addresses, and two mode flags.
    logic [15:0] mq[$];
    logic [22:0] m_pc, m_tail;
    bit          m_partial;
    logic [7:0]  m_low;
    bit          m_fetching, m_flushing;

    function automatic bit m_stall();
        return m_flushing ||
               (m_fetching && (2 * mq.size() + int'(m_partial) >= 7));
    endfunction

    function automatic logic [31:0] m_data();
        logic [15:0] lo, hi;
        lo = 16'h0;
        hi = 16'h0;
        if (mq.size() > 0) lo = mq[0];
        if (mq.size() > 1) hi = mq[1];
        return {hi, lo};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc = 23'h0;
        m_tail = 23'h0;
        m_partial = 0;
        m_low = 8'h0;
        m_fetching = 0;
        m_flushing = 0;
    endtask

    task automatic model_edge();
        if (jump) begin
            mq.delete();
            m_partial = 0;
            m_tail = jump_addr;
            m_pc = jump_addr;
            m_fetching = 0;
            m_flushing = 1;
            return;
        end
        if (instr_take == 2'b01 && mq.size() >= 1) begin
            void'(mq.pop_front());
            m_pc = m_pc + 23'd1;
        end else if (instr_take == 2'b10 && mq.size() >= 2) begin
            void'(mq.pop_front());
            void'(mq.pop_front());
            m_pc = m_pc + 23'd2;
        end
        if (m_flushing) begin
            if (fetch_stopped) m_flushing = 0;
        end else if (m_fetching) begin
            if (fetch_byte_valid) begin
                if (!m_partial) begin
                    m_low = fetch_byte;
                    m_partial = 1;
                end else begin
                    mq.push_back({fetch_byte, m_low});
                    m_tail = m_tail + 23'd1;
                    m_partial = 0;
                end
            end
            if (fetch_stopped) begin
                m_partial = 0;
                m_fetching = 0;
            end
        end else if (fetch_started) begin
            m_fetching = 1;
        end
    endtask

    task automatic cycle(input bit j, input logic [22:0] ja,
                         input logic [1:0] tk, input bit st,
                         input bit sp, input bit bv,
                         input logic [7:0] b);
        jump = j;
        jump_addr = ja;
        instr_take = tk;
        fetch_started = st;
        fetch_stopped = sp;
        fetch_byte_valid = bv;
        fetch_byte = b;
        @(posedge clk);
        if (rstn) model_edge();
        else model_reset();
        #1;
        jump = 0;
        instr_take = 2'b00;
        fetch_started = 0;
        fetch_stopped = 0;
        fetch_byte_valid = 0;
    endtask

    task automatic idle();
        cycle(0, 23'h0, 2'b00, 0, 0, 0, 8'h0);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(0, 23'h0, 2'b00, 0, 0, 1, b);
    endtask

    task automatic do_reset();
        rstn = 0;
        idle();
        rstn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (instr_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", instr_count); end
        checks++; if (instr_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", instr_data); end
        checks++; if (fetch_restart !== 1'b1) begin failures++; $display("FAIL reset_restart got=%b want=1", fetch_restart); end
        checks++; if (fetch_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", fetch_stall); end
        checks++; if (fetch_addr !== 23'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", fetch_addr); end
        checks++; if (instr_pc !== 23'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", instr_pc); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        send(8'hAA);
        checks++; if (instr_count !== 3'd0) begin failures++; $display("FAIL wait_byte_ignored got=%0d want=0", instr_count); end
        checks++; if (fetch_restart !== 1'b1) begin failures++; $display("FAIL restart_before_start got=%b want=1", fetch_restart); end
        cycle(0, 23'h0, 2'b00, 1, 0, 0, 8'h0);
        checks++; if (fetch_restart !== 1'b0) begin failures++; $display("FAIL restart_after_start got=%b want=0", fetch_restart); end
        send(8'h13); send(8'h00); send(8'hB7); send(8'h02);
        checks++; if (instr_count !== 3'd2) begin failures++; $display("FAIL first_count got=%0d want=2", instr_count); end
        checks++; if (instr_data !== 32'h02B70013) begin failures++; $display("FAIL first_data got=%h want=02b70013", instr_data); end
        checks++; if (instr_pc !== 23'h0) begin failures++; $display("FAIL first_pc got=%h want=0", instr_pc); end
        checks++; if (fetch_addr !== 23'h2) begin failures++; $display("FAIL first_tail got=%h want=2", fetch_addr); end
    endtask

    task automatic test_stall_fill();
        logic [7:0] b;
        do_reset();
        cycle(0, 23'h0, 2'b00, 1, 0, 0, 8'h0);
        for (int i = 1; i <= 7; i++) begin
            b = 8'(8'h0F + i);
            send(b);
            checks++; if (fetch_stall !== (i >= 7)) begin failures++; $display("FAIL fill_stall_%0d got=%b want=%b", i, fetch_stall, i >= 7); end
        end
        send(8'h17);
        checks++; if (instr_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d want=4", instr_count); end
        checks++; if (fetch_addr !== 23'h4) begin failures++; $display("FAIL fill_tail got=%h want=4", fetch_addr); end
        checks++; if (fetch_stall !== 1'b1) begin failures++; $display("FAIL fill_stall_full got=%b want=1", fetch_stall); end
        checks++; if (instr_data !== 32'h13121110) begin failures++; $display("FAIL fill_data got=%h want=13121110", instr_data); end
    endtask

    task automatic test_take_full();
        cycle(0, 23'h0, 2'b10, 0, 0, 1, 8'h55);
        checks++; if (instr_count !== 3'd2) begin failures++; $display("FAIL takefull_count got=%0d want=2", instr_count); end
        checks++; if (instr_pc !== 23'h2) begin failures++; $display("FAIL takefull_pc got=%h want=2", instr_pc); end
        checks++; if (fetch_stall !== 1'b0) begin failures++; $display("FAIL takefull_stall got=%b want=0", fetch_stall); end
        send(8'h66);
        checks++; if (instr_count !== 3'd3) begin failures++; $display("FAIL takefull_partial got=%0d want=3", instr_count); end
        checks++; if (instr_data !== 32'h17161514) begin failures++; $display("FAIL takefull_data got=%h want=17161514", instr_data); end
        cycle(0, 23'h0, 2'b10, 0, 0, 0, 8'h0);
        cycle(0, 23'h0, 2'b00, 0, 0, 0, 8'h0);
        checks++; if (instr_data !== 32'h00006655) begin failures++; $display("FAIL takefull_hw got=%h want=00006655", instr_data); end
    endtask

    task automatic test_stopped_partial();
        do_reset();
        cycle(0, 23'h0, 2'b00, 1, 0, 0, 8'h0);
        send(8'h13); send(8'h00); send(8'h13);
        cycle(0, 23'h0, 2'b00, 0, 1, 0, 8'h0);
        checks++; if (fetch_restart !== 1'b1) begin failures++; $display("FAIL stop_restart got=%b want=1", fetch_restart); end
        checks++; if (fetch_addr !== 23'h1) begin failures++; $display("FAIL stop_addr got=%h want=1", fetch_addr); end
        checks++; if (instr_count !== 3'd1) begin failures++; $display("FAIL stop_count got=%0d want=1", instr_count); end
        cycle(0, 23'h0, 2'b00, 1, 0, 0, 8'h0);
        send(8'hAA); send(8'hBB);
        checks++; if (instr_data !== 32'hBBAA0013) begin failures++; $display("FAIL refetch_data got=%h want=bbaa0013", instr_data); end
    endtask

    task automatic test_jump_flush();
        do_reset();
        cycle(0, 23'h0, 2'b00, 1, 0, 0, 8'h0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        cycle(1, 23'h000100, 2'b01, 0, 0, 1, 8'h99);
        checks++; if (instr_count !== 3'd0) begin failures++; $display("FAIL jump_count got=%0d want=0", instr_count); end
        checks++; if (instr_pc !== 23'h100) begin failures++; $display("FAIL jump_pc got=%h want=100", instr_pc); end
        checks++; if (fetch_restart !== 1'b1 || fetch_stall !== 1'b1) begin failures++; $display("FAIL jump_flush got=%b%b want=11", fetch_restart, fetch_stall); end
        cycle(0, 23'h0, 2'b00, 1, 0, 1, 8'h11);
        send(8'h22);
        checks++; if (instr_count !== 3'd0 || fetch_stall !== 1'b1) begin failures++; $display("FAIL flush_ignore got=%0d/%b want=0/1", instr_count, fetch_stall); end
        cycle(0, 23'h0, 2'b00, 0, 1, 0, 8'h0);
        checks++; if (fetch_stall !== 1'b0 || fetch_restart !== 1'b1) begin failures++; $display("FAIL flush_exit got=%b%b want=10", fetch_restart, fetch_stall); end
        checks++; if (fetch_addr !== 23'h100) begin failures++; $display("FAIL flush_addr got=%h want=100", fetch_addr); end
    endtask

    task automatic test_ignored_take_and_wrap();
        do_reset();
        cycle(1, 23'h7FFFFF, 2'b00, 0, 0, 0, 8'h0);
        cycle(0, 23'h0, 2'b00, 0, 1, 0, 8'h0);
        cycle(0, 23'h0, 2'b00, 1, 0, 0, 8'h0);
        send(8'h34); send(8'h12);
        checks++; if (fetch_addr !== 23'h0) begin failures++; $display("FAIL wrap_tail got=%h want=0", fetch_addr); end
        cycle(0, 23'h0, 2'b10, 0, 0, 0, 8'h0);
        checks++; if (instr_count !== 3'd1 || instr_pc !== 23'h7FFFFF) begin failures++; $display("FAIL take2_short got=%0d/%h want=1/7fffff", instr_count, instr_pc); end
        cycle(0, 23'h0, 2'b11, 0, 0, 0, 8'h0);
        checks++; if (instr_count !== 3'd1 || instr_pc !== 23'h7FFFFF) begin failures++; $display("FAIL take_rsvd got=%0d/%h want=1/7fffff", instr_count, instr_pc); end
        checks++; if (instr_data !== 32'h00001234) begin failures++; $display("FAIL wrap_data got=%h want=00001234", instr_data); end
        cycle(0, 23'h0, 2'b01, 0, 0, 0, 8'h0);
        checks++; if (instr_count !== 3'd0 || instr_pc !== 23'h0) begin failures++; $display("FAIL wrap_pc got=%0d/%h want=0/0", instr_count, instr_pc); end
    endtask

    task automatic test_random();
        bit j, st, sp, bv;
        logic [22:0] ja;
        logic [1:0] tk;
        int printed;
        printed = 0;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            j = ($urandom_range(0, 99) < 2);
            ja = ($urandom_range(0, 1) == 0) ? 23'(23'h7FFFFD + $urandom_range(0, 2)) : 23'($urandom);
            tk = 2'($urandom_range(0, 3));
            st = 0; sp = 0; bv = 0;
            if (m_flushing) begin
                sp = ($urandom_range(0, 3) == 0);
                st = ($urandom_range(0, 7) == 0);
                bv = ($urandom_range(0, 1) == 0);
            end else if (m_fetching) begin
                sp = ($urandom_range(0, 29) == 0);
                bv = !m_stall() && ($urandom_range(0, 3) != 0);
            end else begin
                st = ($urandom_range(0, 2) == 0);
                bv = ($urandom_range(0, 3) == 0);
            end
            cycle(j, ja, tk, st, sp, bv, 8'($urandom));
            checks++;
            if (instr_count !== 3'(mq.size()) || instr_data !== m_data() ||
                instr_pc !== m_pc || fetch_addr !== m_tail ||
                fetch_restart !== !m_fetching || fetch_stall !== m_stall()) begin
                failures++;
                if (printed < 10)
                    $display("FAIL rand_%0d got cnt=%0d data=%h pc=%h addr=%h rs=%b%b want cnt=%0d data=%h pc=%h addr=%h rs=%b%b",
                             n, instr_count, instr_data, instr_pc, fetch_addr, fetch_restart, fetch_stall,
                             mq.size(), m_data(), m_pc, m_tail, !m_fetching, m_stall());
                printed++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_fetch();
        test_stall_fill();
        test_take_full();
        test_stopped_partial();
        test_jump_flush();
        test_ignored_take_and_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
